// File: rtl/residue_calc.sv
// Montgomery residue A = 2^nn mod M over a multi-word modulus, computed in the
// operand memory by repeated doubling with one conditional subtraction per step.
module residue_calc (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        calculate,
   output logic        ready,
   input  logic [7:0]  length,
   input  logic [14:0] nn,
   output logic [7:0]  opm_addr,
   input  logic [31:0] opm_data,
   output logic [7:0]  opa_rd_addr,
   input  logic [31:0] opa_rd_data,
   output logic [7:0]  opa_wr_addr,
   output logic [31:0] opa_wr_data,
   output logic        opa_wr_we
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SHIFT, S_COMPARE, S_SUB, S_LOOP, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  length_q, length_d;
   logic [14:0] cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic        ready_q, ready_d;
   logic [7:0]  last_idx;
   logic [32:0] diff;

   always_comb begin
      last_idx = length_q - 8'd1;
      diff     = {1'b0, opa_rd_data} - {1'b0, opm_data} - {32'd0, carry_q};
      state_d  = state_q;
      phase_d  = phase_q;
      idx_d    = idx_q;
      length_d = length_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      ready_d  = ready_q;
      case (state_q)
         S_IDLE: begin
            if (calculate) begin
               length_d = length;
               cnt_d    = nn;
               ready_d  = 1'b0;
               carry_d  = 1'b0;
               phase_d  = 1'b0;
               if (length == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_INIT;
                  idx_d   = length - 8'd1;
               end
            end
         end
         S_INIT: begin
            if (idx_q == 8'd0) begin
               carry_d = 1'b0;
               phase_d = 1'b0;
               idx_d   = last_idx;
               state_d = (cnt_q == 15'd0) ? S_DONE : S_SHIFT;
            end else begin
               idx_d = idx_q - 8'd1;
            end
         end
         S_SHIFT: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               carry_d = opa_rd_data[31];
               if (idx_q != 8'd0) begin
                  idx_d = idx_q - 8'd1;
               end else if (opa_rd_data[31]) begin
                  // carry out of word 0 is ovf: A >= 2^(32*length) > M, subtract at once
                  state_d = S_SUB;
                  idx_d   = last_idx;
                  carry_d = 1'b0;
               end else begin
                  state_d = S_COMPARE;
                  idx_d   = 8'd0;
               end
            end
         end
         S_COMPARE: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (opa_rd_data < opm_data) begin
                  state_d = S_LOOP;
               end else if (opa_rd_data > opm_data || idx_q == last_idx) begin
                  state_d = S_SUB;
                  idx_d   = last_idx;
                  carry_d = 1'b0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_SUB: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               carry_d = diff[32];
               if (idx_q == 8'd0) state_d = S_LOOP;
               else               idx_d   = idx_q - 8'd1;
            end
         end
         S_LOOP: begin
            cnt_d = cnt_q - 15'd1;
            if (cnt_q == 15'd1) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
               idx_d   = last_idx;
               carry_d = 1'b0;
               phase_d = 1'b0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            idx_d   = 8'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         phase_q  <= 1'b0;
         idx_q    <= '0;
         length_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         idx_q    <= idx_d;
         length_q <= length_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         ready_q  <= ready_d;
      end
   end

   assign ready       = ready_q;
   assign opm_addr    = idx_q;
   assign opa_rd_addr = idx_q;
   assign opa_wr_addr = idx_q;

   // write data in SHIFT/SUB comes straight from the memory read port in the data cycle
   always_comb begin
      opa_wr_we   = 1'b0;
      opa_wr_data = '0;
      case (state_q)
         S_INIT: begin
            opa_wr_we   = 1'b1;
            opa_wr_data = (idx_q == last_idx) ? 32'd1 : 32'd0;
         end
         S_SHIFT: if (phase_q) begin
            opa_wr_we   = 1'b1;
            opa_wr_data = {opa_rd_data[30:0], carry_q};
         end
         S_SUB: if (phase_q) begin
            opa_wr_we   = 1'b1;
            opa_wr_data = diff[31:0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_residue_calc.sv
// Self-checking bench for residue_calc: behavioural memories, a vector table,
// an expected-word scoreboard queue, and reset/busy/length-0 sequences.
module tb_residue_calc;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        calculate;
   logic        ready;
   logic [7:0]  length;
   logic [14:0] nn;
   logic [7:0]  opm_addr;
   logic [31:0] opm_data;
   logic [7:0]  opa_rd_addr;
   logic [31:0] opa_rd_data;
   logic [7:0]  opa_wr_addr;
   logic [31:0] opa_wr_data;
   logic        opa_wr_we;

   residue_calc dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .calculate   (calculate),
      .ready       (ready),
      .length      (length),
      .nn          (nn),
      .opm_addr    (opm_addr),
      .opm_data    (opm_data),
      .opa_rd_addr (opa_rd_addr),
      .opa_rd_data (opa_rd_data),
      .opa_wr_addr (opa_wr_addr),
      .opa_wr_data (opa_wr_data),
      .opa_wr_we   (opa_wr_we)
   );

   always #5 clk = ~clk;

   logic [31:0] opm_mem [0:255];
   logic [31:0] opa_mem [0:255];
   logic        clear_mem = 1'b0;
   int unsigned cur_len = 0;
   int unsigned wr_count = 0;
   int unsigned bad_wr = 0;

   always @(posedge clk) begin
      opa_rd_data <= opa_mem[opa_rd_addr];
      opm_data    <= opm_mem[opm_addr];
      if (clear_mem) begin
         for (int i = 0; i < 256; i++) opa_mem[i] <= 32'hDEADBEEF;
         wr_count <= 0;
         bad_wr   <= 0;
      end else if (opa_wr_we) begin
         opa_mem[opa_wr_addr] <= opa_wr_data;
         wr_count <= wr_count + 1;
         if (32'(opa_wr_addr) >= cur_len) bad_wr <= bad_wr + 1;
      end
   end

   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [31:0] exp_q [$];
   localparam int unsigned LIMIT = 5000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One complete run; expected words go into the scoreboard at start and are
   // popped when ready returns.  cyc=0 skips the ready-low cycle-count check.
   task automatic run(input int unsigned len, input int unsigned nn_i,
                      input logic [31:0] m0, input logic [31:0] m1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input int unsigned cyc, input bit pulse_busy, input string tag);
      int unsigned cnt;
      cur_len = len;
      opm_mem[0] = m0;
      opm_mem[1] = m1;
      @(negedge clk) clear_mem = 1'b1;
      @(negedge clk) clear_mem = 1'b0;
      if (len >= 1) exp_q.push_back(e0);
      if (len >= 2) exp_q.push_back(e1);
      calculate = 1'b1;
      length    = 8'(len);
      nn        = 15'(nn_i);
      @(negedge clk);
      calculate = 1'b0;
      check($sformatf("%s_ready_fall", tag), 32'(ready), 32'd0);
      cnt = 0;
      while (ready == 1'b0 && cnt < LIMIT) begin
         cnt++;
         if (pulse_busy && cnt == 4) begin
            calculate = 1'b1;
            length    = 8'd2;
            nn        = 15'd1;
         end else begin
            calculate = 1'b0;
         end
         @(negedge clk);
      end
      calculate = 1'b0;
      check($sformatf("%s_ready_rise", tag), 32'(ready), 32'd1);
      if (cyc != 0) check($sformatf("%s_cycles", tag), cnt, cyc);
      for (int unsigned i = 0; i < len; i++) begin
         check($sformatf("%s_word%0d", tag, i), opa_mem[i], exp_q.pop_front());
      end
      check($sformatf("%s_guard", tag), opa_mem[len], 32'hDEADBEEF);
      check($sformatf("%s_bad_wr", tag), bad_wr, 32'd0);
      if (len == 0) check($sformatf("%s_no_writes", tag), wr_count, 32'd0);
   endtask

   typedef struct {
      int unsigned len;
      int unsigned nn;
      logic [31:0] m0;
      logic [31:0] m1;
      logic [31:0] e0;
      logic [31:0] e1;
      int unsigned cyc;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1, 64, 32'h00000013, 32'h0, 32'h00000011, 32'h0, 0};
      vecs[1] = '{1, 5,  32'h00000011, 32'h0, 32'h0000000F, 32'h0, 29};
      vecs[2] = '{1, 64, 32'h00000011, 32'h0, 32'h00000001, 32'h0, 0};
      vecs[3] = '{1, 0,  32'h00000011, 32'h0, 32'h00000001, 32'h0, 2};
      vecs[4] = '{1, 33, 32'hFFFFFFFB, 32'h0, 32'h0000000A, 32'h0, 167};
      vecs[5] = '{1, 32, 32'hFFFFFFFB, 32'h0, 32'h00000005, 32'h0, 0};
      vecs[6] = '{2, 32, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 0};
      vecs[7] = '{2, 64, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001, 0};
      vecs[8] = '{2, 64, 32'h00000000, 32'h00000013, 32'h00000000, 32'h00000011, 0};
      vecs[9] = '{1, 2,  32'h00000003, 32'h0, 32'h00000001, 32'h0, 0};

      reset_n   = 1'b0;
      calculate = 1'b0;
      length    = 8'd0;
      nn        = 15'd0;
      #12;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we", 32'(opa_wr_we), 32'd0);
      check("rst_wr_addr", 32'(opa_wr_addr), 32'd0);
      check("rst_rd_addr", 32'(opa_rd_addr), 32'd0);
      check("rst_opm_addr", 32'(opm_addr), 32'd0);
      check("rst_wr_data", opa_wr_data, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run(vecs[i].len, vecs[i].nn, vecs[i].m0, vecs[i].m1,
             vecs[i].e0, vecs[i].e1, vecs[i].cyc, 1'b0, $sformatf("v%0d", i));
      end

      run(0, 5, 32'h00000011, 32'h0, 32'h0, 32'h0, 1, 1'b0, "len0");
      run(1, 5, 32'h00000011, 32'h0, 32'h0000000F, 32'h0, 29, 1'b1, "busy");

      // asynchronous reset in the middle of a SHIFT write cycle
      cur_len = 1;
      opm_mem[0] = 32'h00000013;
      @(negedge clk);
      calculate = 1'b1;
      length    = 8'd1;
      nn        = 15'd64;
      @(negedge clk);
      calculate = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_we", 32'(opa_wr_we), 32'd1);
      check("pre_reset_ready", 32'(ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("async_ready", 32'(ready), 32'd1);
      check("async_we", 32'(opa_wr_we), 32'd0);
      check("async_wr_addr", 32'(opa_wr_addr), 32'd0);
      check("async_wr_data", opa_wr_data, 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      run(1, 64, 32'h00000013, 32'h0, 32'h00000011, 32'h0, 0, 1'b0, "after_rst");

      check("sb_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/residue_calc.md
# residue_calc

Computes the Montgomery residue 2^nn mod M for a multi-word modulus by repeated doubling with conditional subtraction. Sits directly upstream of montprod in the modexp datapath. It writes its result into the operand memory that montprod later reads as an operand, so operands can be converted into the Montgomery domain. M is read from the shared modulus memory. Words are 32 bit: index 0 is the most significant word, index length-1 the least significant.

## Interface
- No parameters; word width fixed at 32, memory depth 256 words.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- calculate  in  1  start pulse; sampled only while ready=1.
- ready  out  1  high when idle or finished.
- length  in  8  operand length in words; sampled at start.
- nn  in  15  number of doublings (e.g. 64*length for R^2); sampled at start.
- opm_addr  out  8  modulus memory read address.
- opm_data  in  32  modulus word; valid the cycle after the address is presented (synchronous read).
- opa_rd_addr  out  8  result/working memory read address.
- opa_rd_data  in  32  working word; valid the cycle after the address is presented (synchronous read).
- opa_wr_addr  out  8  working memory write address.
- opa_wr_data  out  32  working memory write data.
- opa_wr_we  out  1  write enable; the write is committed on the rising edge while high.

## Operation
- Computes A = 2^nn mod M in the working memory (words 0..length-1).
- Preconditions: M odd, M > 1. Behaviour for other M is unspecified but must terminate.
- **IDLE:** ready=1. When calculate=1, latch length and nn, set ready=0, go to INIT.
  - If length=0, go to DONE directly; no writes occur.
- **INIT:** write A = 1, one word per cycle, from index length-1 down to 0.
  - Word length-1 gets 0x00000001; all other words get 0.
  - Loop counter = nn. If nn=0, go to DONE; otherwise go to SHIFT.
- **SHIFT:** A = A<<1, processed from word length-1 down to 0 with a 1-bit carry.
  - Each word is a read followed by a write: {word[30:0], carry_in}.
  - The carry out of word 0 is latched as ovf.
  - If ovf=1, go to SUB; otherwise go to COMPARE.
- **COMPARE:** read A and M at the same index, from word 0 upward.
  - On the first word where they differ, ge = (A_word > M_word), and the scan ends.
  - If all words are equal, ge=1.
  - If ge=1, go to SUB; otherwise go to LOOP.
- **SUB:** A = A - M, processed from word length-1 down to 0 with a 1-bit borrow.
  - The final borrow is discarded; it cancels ovf when ovf=1.
  - Then go to LOOP.
- **LOOP:** decrement the counter. If it reaches 0, go to DONE; otherwise go to SHIFT.
- **DONE:** one cycle, then IDLE with ready=1.
- Invariant: A < M after every iteration, so one subtraction per doubling is always sufficient.
- calculate while ready=0 is ignored.

## Timing
- Reset values: ready=1, opa_wr_we=0, all addresses 0, opa_wr_data=0, FSM=IDLE, counter=0, ovf=0.
- Reset mid-operation: outputs return to reset values immediately (asynchronous). The working memory contents are then undefined.
- ready falls on the first rising edge after calculate is sampled high. It rises on the edge that enters IDLE from DONE.
- Cycle counts per state:
  - INIT: length cycles, one write per cycle.
  - SHIFT and SUB: 2 cycles per word (address cycle, then data/write cycle) = 2*length each.
  - COMPARE: 2 cycles per word examined; it exits early on the first differing word and is skipped when ovf=1.
  - LOOP and DONE: 1 cycle each.
- A write to index i in SHIFT/SUB always precedes the read of index i-1, so there is no read-after-write hazard on the same word.
- opa_wr_we is high only in INIT, the write cycles of SHIFT, and the write cycles of SUB.
- Worst-case latency: 1 + length + nn*(6*length+1) + 1 cycles.

## Test plan
- length=1, M=0x00000013, nn=64 -> ready returns, word0=0x00000011; no writes beyond index 0.
- length=1, M=0x00000011: nn=5 -> 0x0000000F; nn=64 -> 0x00000001; nn=0 -> 0x00000001, with ready after INIT+DONE.
- Overflow path: length=1, M=0xFFFFFFFB, nn=33 -> 0x0000000A. The 32nd doubling must set ovf and take SUB without COMPARE.
- length=2, M={0x00000001,0x00000001}: nn=32 -> {0x00000001,0x00000000}; nn=64 -> {0x00000000,0x00000001}.
- length=0, calculate -> opa_wr_we never asserted; ready high again within 3 cycles.
- Reset mid-SHIFT, and calculate pulsed while busy:
  - Pulling reset_n low forces ready=1 and opa_wr_we=0 without a clock edge.
  - A calculate pulse while busy has no effect.
  - A following run with length=1, M=0x13, nn=64 yields 0x00000011.
